// File: rtl/spi_reg_bridge.sv
// rtl/spi_reg_bridge.sv - SPI byte stream to register-bus write bridge with request FIFO and status byte
// Optional feature macro: SPI_REG_BRIDGE_AUTOINC_EN (address auto-increment within a transaction)

module spi_reg_bridge #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] spi_addr,
   input  logic [7:0] spi_data,
   input  logic       spi_first,
   input  logic       spi_last,
   input  logic       spi_strobe,
   output logic [7:0] spi_out,
   output logic [7:0] bus_addr,
   output logic [7:0] bus_data,
   output logic       bus_valid,
   input  logic       bus_ready
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   LVL_ONE  = 1;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = 1;

   logic [15:0]           mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   level;
   logic [DEPTH_LOG2:0]   level_nxt;
   logic                  ovf;
   logic                  ovf_nxt;
   logic                  last_q;
   logic                  full;
   logic                  nonempty;
   logic                  pop;
   logic                  push;
   logic                  drop;
   logic                  last_rise;
   logic [7:0]            entry_addr;
   logic [15:0]           head;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   logic [7:0] next_addr;

   // Track the address of the next byte; dropped bytes still consume an address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         next_addr <= 8'h00;
      end else if (spi_strobe) begin
         next_addr <= entry_addr + 8'd1;
      end
   end

   // First byte of a transaction takes the SPI address, later bytes the running one.
   always_comb begin
      entry_addr = spi_first ? spi_addr : next_addr;
   end
`else
   // Without auto-increment every byte targets the same register.
   always_comb begin
      entry_addr = spi_addr;
   end
`endif

   // Handshake, push/drop decisions and next-state status values.
   always_comb begin
      full      = (level == FULL_LVL);
      nonempty  = (level != '0);
      pop       = nonempty & bus_ready;
      push      = spi_strobe & (~full | pop);
      drop      = spi_strobe & full & ~pop;
      last_rise = spi_last & ~last_q;
      level_nxt = level;
      if (push && !pop) begin
         level_nxt = level + LVL_ONE;
      end else if (pop && !push) begin
         level_nxt = level - LVL_ONE;
      end
      ovf_nxt = ovf;
      if (last_rise) begin
         ovf_nxt = 1'b0;
      end
      if (drop) begin
         ovf_nxt = 1'b1;
      end
   end

   // Storage array; a full-and-popping write lands in the slot being vacated.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {entry_addr, spi_data};
      end
   end

   // Pointers, level, overflow flag and chip-select edge register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         ovf    <= 1'b0;
         last_q <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         level  <= level_nxt;
         ovf    <= ovf_nxt;
         last_q <= spi_last;
      end
   end

   // Status byte is built from next-state values so it tracks the level one cycle after a push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spi_out <= 8'h00;
      end else begin
         spi_out <= {ovf_nxt, (level_nxt != '0), 6'(level_nxt)};
      end
   end

   // Show-ahead head entry; forced to zero when empty so reset clears the bus outputs at once.
   always_comb begin
      head      = mem[rd_ptr];
      bus_valid = nonempty;
      bus_addr  = nonempty ? head[15:8] : 8'h00;
      bus_data  = nonempty ? head[7:0]  : 8'h00;
   end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// tb/tb_spi_reg_bridge.sv - scoreboard testbench for spi_reg_bridge

module tb_spi_reg_bridge;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] spi_addr = 8'h00;
   logic [7:0] spi_data = 8'h00;
   logic       spi_first = 1'b0;
   logic       spi_last = 1'b0;
   logic       spi_strobe = 1'b0;
   logic [7:0] spi_out;
   logic [7:0] bus_addr;
   logic [7:0] bus_data;
   logic       bus_valid;
   logic       bus_ready = 1'b0;

`ifdef SPI_REG_BRIDGE_AUTOINC_EN
   localparam logic [7:0] AUTO_K = 8'd1;
`else
   localparam logic [7:0] AUTO_K = 8'd0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] d;
      int         c;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   spi_reg_bridge #(.DEPTH_LOG2(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_addr   (spi_addr),
      .spi_data   (spi_data),
      .spi_first  (spi_first),
      .spi_last   (spi_last),
      .spi_strobe (spi_strobe),
      .spi_out    (spi_out),
      .bus_addr   (bus_addr),
      .bus_data   (bus_data),
      .bus_valid  (bus_valid),
      .bus_ready  (bus_ready)
   );

   function automatic logic [7:0] ea(input logic [7:0] base, input logic [7:0] off);
      return base + off * AUTO_K;
   endfunction

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic strobe(input logic first, input logic [7:0] d, input logic [7:0] a,
                         input bit stored, input bit timed);
      exp_t e;
      spi_first  = first;
      spi_data   = d;
      spi_strobe = 1'b1;
      if (stored) begin
         e.a = a;
         e.d = d;
         e.c = timed ? cyc + 1 : 0;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      spi_strobe = 1'b0;
      spi_first  = 1'b0;
   endtask

   task automatic chk_out(input string name, input logic [7:0] exp);
      @(negedge clk);
      check8(name, spi_out, exp);
      @(posedge clk); #1;
   endtask

   task automatic drain(input string name);
      bus_ready = 1'b1;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      bus_ready = 1'b0;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s: %0d entries still expected, required 0", name, exp_q.size());
      end
   endtask

   // Scoreboard monitor: every bus transfer must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst && bus_valid && bus_ready) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL bus_unexpected: got addr 0x%02h data 0x%02h, required no transfer",
                     bus_addr, bus_data);
         end else begin
            e_mon = exp_q.pop_front();
            if (bus_addr !== e_mon.a || bus_data !== e_mon.d || (e_mon.c != 0 && cyc != e_mon.c)) begin
               n_fail++;
               $display("FAIL bus_write: got addr 0x%02h data 0x%02h cycle %0d, required addr 0x%02h data 0x%02h cycle %0d",
                        bus_addr, bus_data, cyc, e_mon.a, e_mon.d, e_mon.c);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset values, asynchronously before any clock edge
      #2;
      check8("rst_spi_out", spi_out, 8'h00);
      check8("rst_bus_valid", {7'b0, bus_valid}, 8'h00);
      check8("rst_bus_addr", bus_addr, 8'h00);
      check8("rst_bus_data", bus_data, 8'h00);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk_out("post_rst_spi_out", 8'h00);

      // Address sequencing across the 0xFF wrap, one cycle strobe-to-bus latency
      bus_ready = 1'b1;
      spi_addr  = 8'hFE;
      strobe(1'b1, 8'h11, 8'hFE,          1'b1, 1'b1);
      strobe(1'b0, 8'h22, ea(8'hFE, 8'd1), 1'b1, 1'b1);
      strobe(1'b0, 8'h33, ea(8'hFE, 8'd2), 1'b1, 1'b1);
      drain("wrap_drain");
      chk_out("wrap_idle_spi_out", 8'h00);
      spi_last = 1'b1;
      @(posedge clk); #1;
      spi_last = 1'b0;
      @(posedge clk); #1;

      // Fill a 4-deep FIFO with 6 strobes while the bus stalls
      bus_ready = 1'b0;
      spi_addr  = 8'h20;
      strobe(1'b1, 8'h01, 8'h20,           1'b1, 1'b0);
      strobe(1'b0, 8'h02, ea(8'h20, 8'd1), 1'b1, 1'b0);
      strobe(1'b0, 8'h03, ea(8'h20, 8'd2), 1'b1, 1'b0);
      strobe(1'b0, 8'h04, ea(8'h20, 8'd3), 1'b1, 1'b0);
      strobe(1'b0, 8'h05, 8'h00,           1'b0, 1'b0);
      strobe(1'b0, 8'h06, 8'h00,           1'b0, 1'b0);
      @(negedge clk);
      check8("fill_spi_out", spi_out, 8'hC4);
      check8("fill_bus_valid", {7'b0, bus_valid}, 8'h01);
      check8("fill_head_addr", bus_addr, 8'h20);
      check8("fill_head_data", bus_data, 8'h01);
      @(posedge clk); #1;
      drain("fill_drain");
      chk_out("fill_after_drain", 8'h80);

      // Overflow clears on spi_last rising
      spi_last = 1'b1;
      @(posedge clk); #1;
      chk_out("ovf_clear", 8'h00);
      spi_last = 1'b0;
      @(posedge clk); #1;

      // Full FIFO with simultaneous pop and push: no overflow, level stays 4
      spi_addr = 8'h50;
      strobe(1'b1, 8'hA0, 8'h50,           1'b1, 1'b0);
      strobe(1'b0, 8'hA1, ea(8'h50, 8'd1), 1'b1, 1'b0);
      strobe(1'b0, 8'hA2, ea(8'h50, 8'd2), 1'b1, 1'b0);
      strobe(1'b0, 8'hA3, ea(8'h50, 8'd3), 1'b1, 1'b0);
      chk_out("full_spi_out", 8'h44);
      bus_ready = 1'b1;
      strobe(1'b0, 8'hA4, ea(8'h50, 8'd4), 1'b1, 1'b0);
      bus_ready = 1'b0;
      chk_out("pushpop_spi_out", 8'h44);
      drain("pushpop_drain");
      chk_out("pushpop_after_drain", 8'h00);

      // Overflow in the same cycle as the clearing edge: set wins
      spi_addr = 8'h60;
      strobe(1'b1, 8'hB0, 8'h60,           1'b1, 1'b0);
      strobe(1'b0, 8'hB1, ea(8'h60, 8'd1), 1'b1, 1'b0);
      strobe(1'b0, 8'hB2, ea(8'h60, 8'd2), 1'b1, 1'b0);
      strobe(1'b0, 8'hB3, ea(8'h60, 8'd3), 1'b1, 1'b0);
      strobe(1'b0, 8'hB4, 8'h00,           1'b0, 1'b0);
      chk_out("ovf2_spi_out", 8'hC4);
      spi_last = 1'b1;
      strobe(1'b0, 8'hB5, 8'h00,           1'b0, 1'b0);
      chk_out("ovf_set_wins", 8'hC4);
      drain("ovf2_drain");
      chk_out("ovf2_after_drain", 8'h80);
      spi_last = 1'b0;
      @(posedge clk); #1;
      spi_last = 1'b1;
      @(posedge clk); #1;
      chk_out("ovf2_clear", 8'h00);
      spi_last = 1'b0;

      // Byte arriving the cycle after chip-select rise is still pushed
      bus_ready = 1'b1;
      spi_addr  = 8'h90;
      spi_last  = 1'b1;
      @(posedge clk); #1;
      strobe(1'b1, 8'hC0, 8'h90, 1'b1, 1'b1);
      drain("late_byte_drain");
      spi_last = 1'b0;
      @(posedge clk); #1;

      // Asynchronous reset mid-operation drops queued entries immediately
      spi_addr = 8'h70;
      strobe(1'b1, 8'hD0, 8'h70,           1'b1, 1'b0);
      strobe(1'b0, 8'hD1, ea(8'h70, 8'd1), 1'b1, 1'b0);
      chk_out("pre_rst_spi_out", 8'h42);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check8("midrst_bus_valid", {7'b0, bus_valid}, 8'h00);
      check8("midrst_bus_addr", bus_addr, 8'h00);
      check8("midrst_bus_data", bus_data, 8'h00);
      check8("midrst_spi_out", spi_out, 8'h00);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus_ready = 1'b1;
      chk_out("after_midrst_spi_out", 8'h00);
      @(negedge clk);
      check8("after_midrst_bus_valid", {7'b0, bus_valid}, 8'h00);
      @(posedge clk); #1;
      bus_ready = 1'b0;

      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_queue: %0d entries left, required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_reg_bridge.md
# spi_reg_bridge

Transaction controller sitting between the SPI slave byte interface and the internal register bus. Turns each SPI data-byte strobe into a write request `{address, data}`, buffers requests in a small FIFO so a stalling bus target never loses bytes at SPI rate, and sequences them onto a valid/ready register bus. Also generates the status byte the SPI slave shifts out at the start of every transaction.

## Interface

Parameters:
- `DEPTH_LOG2`, default 4: log2 of the FIFO depth in entries. Legal range 1..5, giving 2..32 entries.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock; the SPI slave runs on the same clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `spi_addr`  in  8  address byte of the current SPI transaction; stable after the first byte.
- `spi_data`  in  8  data byte; valid in the cycle `spi_strobe` is high.
- `spi_first`  in  1  high until the first data strobe of the transaction has been seen.
- `spi_last`  in  1  goes high when chip-select deasserts; returns low at the next chip-select assertion.
- `spi_strobe`  in  1  single-cycle pulse, one per received data byte.
- `spi_out`  out  8  status byte, registered; the SPI slave samples it at chip-select fall.
- `bus_addr`  out  8  register address of the head request.
- `bus_data`  out  8  write data of the head request.
- `bus_valid`  out  1  a head request is present.
- `bus_ready`  in  1  target accepts the head request; a transfer occurs in a cycle where `bus_valid & bus_ready`.

## Operation

- **FIFO.** 16-bit entries `{addr, data}`, `2**DEPTH_LOG2` deep. Read and write pointers are `DEPTH_LOG2` bits wide and wrap modulo depth. Level counter is `DEPTH_LOG2+1` bits. Show-ahead: the head entry drives `bus_addr` and `bus_data` directly from registers.
- **Push.** A push happens on every `spi_strobe`:
  - If the FIFO is not full, the entry is written.
  - If the FIFO is full and a pop occurs in the same cycle, the entry is still written; the level is unchanged.
  - If the FIFO is full and no pop occurs, the byte is dropped and sticky `ovf` is set.
- **Pop.** A pop happens when `bus_valid & bus_ready`. The pointer advances, and the next entry, if any, is presented in the following cycle.
- **Address sequencing.** With auto-increment enabled:
  - Strobe with `spi_first=1`: entry address is `spi_addr`, and `next_addr` is loaded with `spi_addr+1`.
  - Strobe with `spi_first=0`: entry address is `next_addr`, and `next_addr` increments.
  - All address arithmetic is 8-bit and wraps, so 0xFF is followed by 0x00.
  - `next_addr` also advances on a dropped byte. Later bytes therefore keep their intended addresses.
- **Status byte.** `spi_out = {ovf, nonempty, level}`:
  - `ovf` is the sticky overflow flag.
  - `nonempty` is 1 when `level != 0`.
  - `level` is 6 bits, zero-extended from the level counter.
  - `spi_out` updates every cycle from the registered state.
- **Overflow clear.** `ovf` clears on the rising edge of `spi_last`, i.e. at the end of the transaction that shipped it out. If an overflow occurs in the same cycle as the clear, the set wins.
- **Write-only.** The bridge issues only writes. Readback of registers is out of scope; the status byte is the only read data.

## Timing

- Reset values: `spi_out=0x00`, `bus_valid=0`, `bus_addr=0x00`, `bus_data=0x00`. Internally: `ovf=0`, level 0, pointers 0, `next_addr=0x00`, the `spi_last` edge register 0.
- Latency from strobe to bus:
  - A strobe in cycle N into an empty FIFO gives `bus_valid=1` with that entry in cycle N+1.
  - With `bus_ready` held high, throughput is one entry per cycle.
- Handshake rules:
  - Once `bus_valid` is asserted, it and `bus_addr`/`bus_data` stay constant until the transfer cycle.
  - `bus_valid` must not depend combinationally on `bus_ready`.
- `spi_out` lags the level change by one cycle: push in N gives the new level in `spi_out` at N+1.
- Reset mid-operation: asserting `rst` immediately empties the FIFO and drops `bus_valid`, asynchronously, with no partial transfer. Entries in flight are lost.
- A strobe arriving on the cycle after `spi_last` rises (the final byte at chip-select rise) is pushed normally.

## Configuration

- `SPI_REG_BRIDGE_AUTOINC_EN` defined: address sequencing auto-increments as described in Operation.
- Not defined: every entry uses `spi_addr` unchanged. This makes a transaction a byte stream into a single register, such as a FIFO port. `next_addr` and its adder are not synthesised.

## Test plan

- **Reset values:** assert `rst` during traffic → all outputs read 0x00/0 asynchronously, in the same cycle; after release, `spi_out=0x00`.
- **Auto-increment with wrap:** `AUTOINC_EN`, `bus_ready=1`, transaction with `spi_addr=0xFE` and data 0x11, 0x22, 0x33 → bus writes (0xFE,0x11), (0xFF,0x22), (0x00,0x33), each one cycle after its strobe.
- **Fill and overflow:** `DEPTH_LOG2=2`, `bus_ready=0`, 6 strobes → level 4, `spi_out=0xC4`, bytes 5–6 dropped. Then release `bus_ready` → exactly the 4 stored entries, in order, with addresses base+0..3.
- **Simultaneous push and pop when full:** FIFO full, `bus_ready=1`, strobe in the same cycle → no `ovf`, level stays at depth, new entry appears last.
- **Overflow clear:** with `ovf=1`, raise `spi_last` → `ovf=0` next cycle. Repeat with an overflowing strobe in the same cycle as the edge → `ovf` stays 1.
- **Auto-increment compiled out:** macro undefined, `spi_addr=0x40`, three bytes → all three writes go to 0x40.
